// File: rtl/if_pll_reconfig_ctrl_if.sv
// if_pll_reconfig_ctrl_if: retune request side plus PLL reconfig-port and status signals
interface if_pll_reconfig_ctrl_if;
  logic [8:0] if_freq;
  logic       freq_strobe;
  logic       rc_busy;
  logic       pll_lock;
  logic [3:0] rc_counter_type;
  logic [2:0] rc_counter_param;
  logic [8:0] rc_data_in;
  logic       rc_write_param;
  logic       rc_reconfig;
  logic       pll_areset;
  logic       busy;
  logic       locked;
  logic       error;
  modport master (
    output if_freq, freq_strobe, rc_busy, pll_lock,
    input  rc_counter_type, rc_counter_param, rc_data_in, rc_write_param, rc_reconfig,
           pll_areset, busy, locked, error
  );
  modport slave (
    input  if_freq, freq_strobe, rc_busy, pll_lock,
    output rc_counter_type, rc_counter_param, rc_data_in, rc_write_param, rc_reconfig,
           pll_areset, busy, locked, error
  );
endinterface

// File: rtl/if_pll_reconfig_ctrl.sv
// if_pll_reconfig_ctrl: writes M/N/C0 into the PLL reconfig block, reconfigures, resets and waits for lock with retry
module if_pll_reconfig_ctrl #(
  parameter int N_DIV        = 1,
  parameter int C_DIV        = 4,
  parameter int M_MIN        = 4,
  parameter int M_MAX        = 400,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RESET_CYCLES = 16,
  parameter int MAX_RETRY    = 3
) (
  input logic clk,
  input logic rst_n,
  if_pll_reconfig_ctrl_if.slave pif
);
  localparam int TMAX = LOCK_TIMEOUT > RESET_CYCLES ? LOCK_TIMEOUT : RESET_CYCLES;
  localparam int CW = $clog2(TMAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  // Each write/wait pair and the reconfig steps are adjacent so the next step is state + 1.
  typedef enum logic [3:0] {
    IDLE, WR_M, WAIT_M, WR_N, WAIT_N, WR_C, WAIT_C, RECONFIG, WAIT_RC, PRESET, WAIT_LOCK, DONE, FAIL
  } state_t;
  state_t state, nxt;
  logic [8:0] m_val, pend_val, req_val;
  logic pend_vld, req_vld, req_ok, seen, sync1, lock_s;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  always_comb begin
    nxt = state_t'(state + 4'd1);
    req_vld = pif.freq_strobe | pend_vld;
    req_val = pif.freq_strobe ? pif.if_freq : pend_val;
    req_ok = req_val >= 9'(M_MIN) && req_val <= 9'(M_MAX);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m_val <= '0;
      pend_val <= '0;
      pend_vld <= 1'b0;
      seen <= 1'b0;
      sync1 <= 1'b0;
      lock_s <= 1'b0;
      cnt <= '0;
      retry <= '0;
      pif.rc_counter_type <= '0;
      pif.rc_counter_param <= '0;
      pif.rc_data_in <= '0;
      pif.rc_write_param <= 1'b0;
      pif.rc_reconfig <= 1'b0;
      pif.pll_areset <= 1'b0;
      pif.busy <= 1'b0;
      pif.locked <= 1'b0;
      pif.error <= 1'b0;
    end else begin
      sync1 <= pif.pll_lock;
      lock_s <= sync1;
      pif.rc_write_param <= 1'b0;
      pif.rc_reconfig <= 1'b0;
      if (pif.freq_strobe && state != IDLE) begin
        pend_vld <= 1'b1;
        pend_val <= pif.if_freq;
      end
      case (state)
        IDLE: begin
          pif.locked <= lock_s;
          if (req_vld) begin
            pend_vld <= 1'b0;
            if (req_ok) begin
              m_val <= req_val;
              pif.error <= 1'b0;
              pif.busy <= 1'b1;
              pif.locked <= 1'b0;
              state <= WR_M;
            end else pif.error <= 1'b1;
          end
        end
        WR_M, WR_N, WR_C: if (!pif.rc_busy) begin
          pif.rc_write_param <= 1'b1;
          pif.rc_counter_param <= 3'd7;
          pif.rc_counter_type <= state == WR_M ? 4'd1 : state == WR_N ? 4'd0 : 4'd4;
          pif.rc_data_in <= state == WR_M ? m_val : state == WR_N ? 9'(N_DIV) : 9'(C_DIV);
          seen <= 1'b0;
          cnt <= '0;
          state <= nxt;
        end
        // A write with no busy response within 4 cycles is taken as complete.
        WAIT_M, WAIT_N, WAIT_C, WAIT_RC: begin
          cnt <= cnt + 1'b1;
          if (pif.rc_busy) seen <= 1'b1;
          else if (seen || cnt == CW'(3)) begin
            cnt <= '0;
            pif.pll_areset <= state == WAIT_RC;
            state <= nxt;
          end
        end
        RECONFIG: begin
          pif.rc_reconfig <= 1'b1;
          seen <= 1'b0;
          cnt <= '0;
          state <= WAIT_RC;
        end
        PRESET: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(RESET_CYCLES - 1)) begin
            cnt <= '0;
            pif.pll_areset <= 1'b0;
            state <= WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          cnt <= cnt + 1'b1;
          if (lock_s) begin
            pif.busy <= 1'b0;
            pif.locked <= 1'b1;
            state <= DONE;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            cnt <= '0;
            if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              pif.pll_areset <= 1'b1;
              state <= PRESET;
            end else begin
              pif.busy <= 1'b0;
              pif.error <= 1'b1;
              state <= FAIL;
            end
          end
        end
        DONE: begin
          retry <= '0;
          pif.locked <= lock_s;
          state <= IDLE;
        end
        FAIL: begin
          retry <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_pll_reconfig_ctrl.sv
// tb_if_pll_reconfig_ctrl: directed tests of the IF PLL retune sequencer with a reconfig-busy and PLL lock model
module tb_if_pll_reconfig_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  if_pll_reconfig_ctrl_if pif();
  if_pll_reconfig_ctrl #(.LOCK_TIMEOUT(100)) dut (.clk(clk), .rst_n(rst_n), .pif(pif));
  always #5 clk = ~clk;

  int passed = 0, total = 0, cyc = 0;
  logic lock_mdl = 1'b0, lock_en = 1'b0, lock_kill = 1'b0;
  int lcnt = 0, bcnt = 0;
  int wr_type[$], wr_data[$];
  int n_rc = 0, n_ar = 0, ar_w = 0, ar_run = 0, dbl = 0;
  int t_lock = -1, t_locked = -1, t_busy_fall = -1;
  logic prev_wp = 1'b0, prev_rc = 1'b0, prev_ar = 1'b0, prev_lk = 1'b0, prev_bz = 1'b0;

  assign pif.pll_lock = lock_mdl & ~lock_kill;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus reconfig-block (3-cycle busy per pulse) and PLL (locks 50 cycles after reset) models.
  always @(negedge clk) begin
    if (pif.rc_write_param) begin
      wr_type.push_back(int'(pif.rc_counter_type));
      wr_data.push_back(int'(pif.rc_data_in));
    end
    if (pif.rc_reconfig) n_rc++;
    if ((pif.rc_write_param && prev_wp) || (pif.rc_reconfig && prev_rc)) dbl++;
    if (pif.pll_areset && !prev_ar) n_ar++;
    if (pif.pll_areset) ar_run++;
    else if (prev_ar) begin ar_w = ar_run; ar_run = 0; end
    if (pif.locked && !prev_lk) t_locked = cyc;
    if (!pif.busy && prev_bz) t_busy_fall = cyc;
    prev_wp = pif.rc_write_param; prev_rc = pif.rc_reconfig; prev_ar = pif.pll_areset;
    prev_lk = pif.locked; prev_bz = pif.busy;
    if (pif.rc_write_param || pif.rc_reconfig) bcnt = 3;
    pif.rc_busy = bcnt != 0;
    if (bcnt != 0) bcnt--;
    if (pif.pll_areset) begin lcnt = 0; lock_mdl = 1'b0; end
    else if (lock_en && !lock_mdl) begin
      if (lcnt == 50) begin lock_mdl = 1'b1; t_lock = cyc; end
      else lcnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int v);
    pif.if_freq = 9'(v);
    pif.freq_strobe = 1'b1;
    @(negedge clk);
    pif.freq_strobe = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (pif.busy === lvl) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    pif.if_freq = '0;
    pif.freq_strobe = 1'b0;
    rst_n = 1'b0;
    tick(3);
    total++;
    if ({pif.rc_counter_type, pif.rc_counter_param, pif.rc_data_in, pif.rc_write_param, pif.rc_reconfig} !== 18'd0)
      $display("FAIL reset_rc: got %h want 0", {pif.rc_counter_type, pif.rc_counter_param, pif.rc_data_in, pif.rc_write_param, pif.rc_reconfig});
    else passed++;
    total++;
    if ({pif.pll_areset, pif.busy, pif.locked, pif.error} !== 4'b0000)
      $display("FAIL reset_status: got %b want 0000", {pif.pll_areset, pif.busy, pif.locked, pif.error});
    else passed++;
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_legal_retune;
    int et[3] = '{1, 0, 4};
    int ed[3] = '{100, 1, 4};
    bit ok;
    wr_type.delete(); wr_data.delete();
    n_rc = 0;
    lock_en = 1'b1;
    strobe(100);
    total++;
    if (pif.busy !== 1'b1) $display("FAIL legal_busy_rise: got %b want 1", pif.busy); else passed++;
    wait_busy(1'b0, 500, ok);
    total++;
    if (!ok) $display("FAIL legal_done_timeout: got busy %b want 0", pif.busy); else passed++;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= wr_type.size()) $display("FAIL legal_write%0d: got none want (%0d,%0d)", i, et[i], ed[i]);
      else if (wr_type[i] != et[i] || wr_data[i] != ed[i])
        $display("FAIL legal_write%0d: got (%0d,%0d) want (%0d,%0d)", i, wr_type[i], wr_data[i], et[i], ed[i]);
      else passed++;
    end
    total++;
    if (wr_type.size() != 3) $display("FAIL legal_write_count: got %0d want 3", wr_type.size()); else passed++;
    total++;
    if (pif.rc_counter_param !== 3'd7) $display("FAIL legal_param: got %0d want 7", pif.rc_counter_param); else passed++;
    total++;
    if (n_rc != 1) $display("FAIL legal_reconfig_count: got %0d want 1", n_rc); else passed++;
    total++;
    if (ar_w != 16) $display("FAIL legal_areset_width: got %0d want 16", ar_w); else passed++;
    total++;
    if (t_locked - t_lock != 3) $display("FAIL legal_lock_latency: got %0d want 3", t_locked - t_lock); else passed++;
    total++;
    if (t_busy_fall != t_locked) $display("FAIL legal_busy_fall: got cycle %0d want %0d", t_busy_fall, t_locked); else passed++;
    total++;
    if ({pif.locked, pif.error} !== 2'b10) $display("FAIL legal_status: got locked,error=%b want 10", {pif.locked, pif.error}); else passed++;
    total++;
    if (dbl != 0) $display("FAIL legal_pulse_width: got %0d double pulses want 0", dbl); else passed++;
  endtask

  task automatic test_lock_loss;
    int n0, r0;
    n0 = wr_type.size();
    r0 = n_rc;
    lock_kill = 1'b1;
    tick(3);
    total++;
    if (pif.locked !== 1'b0) $display("FAIL lossy_locked: got %b want 0", pif.locked); else passed++;
    tick(5);
    total++;
    if (wr_type.size() != n0 || n_rc != r0 || pif.pll_areset !== 1'b0 || pif.busy !== 1'b0)
      $display("FAIL loss_no_retune: got writes %0d reconf %0d areset %b busy %b want %0d %0d 0 0",
               wr_type.size(), n_rc, pif.pll_areset, pif.busy, n0, r0);
    else passed++;
    lock_kill = 1'b0;
    tick(4);
    total++;
    if (pif.locked !== 1'b1) $display("FAIL loss_relock_idle: got %b want 1", pif.locked); else passed++;
  endtask

  task automatic test_range_reject;
    int n0, r0, a0;
    int vals[3] = '{2, 450, 401};
    n0 = wr_type.size(); r0 = n_rc; a0 = n_ar;
    foreach (vals[i]) begin
      strobe(vals[i]);
      total++;
      if ({pif.error, pif.busy} !== 2'b10)
        $display("FAIL reject_%0d: got error,busy=%b want 10", vals[i], {pif.error, pif.busy});
      else passed++;
    end
    tick(10);
    total++;
    if (wr_type.size() != n0 || n_rc != r0 || n_ar != a0 || pif.busy !== 1'b0)
      $display("FAIL reject_no_activity: got writes %0d reconf %0d areset %0d busy %b want %0d %0d %0d 0",
               wr_type.size(), n_rc, n_ar, pif.busy, n0, r0, a0);
    else passed++;
  endtask

  task automatic test_lock_timeout;
    int a0;
    bit ok;
    lock_en = 1'b0;
    a0 = n_ar;
    strobe(200);
    wait_busy(1'b0, 3000, ok);
    total++;
    if (!ok) $display("FAIL timeout_end: got busy %b want 0", pif.busy); else passed++;
    tick(2);
    total++;
    if (n_ar - a0 != 4) $display("FAIL timeout_areset_count: got %0d want 4", n_ar - a0); else passed++;
    total++;
    if ({pif.error, pif.busy, pif.locked} !== 3'b100)
      $display("FAIL timeout_status: got error,busy,locked=%b want 100", {pif.error, pif.busy, pif.locked});
    else passed++;
    lock_en = 1'b1;
    wr_type.delete(); wr_data.delete();
    strobe(4);
    total++;
    if ({pif.error, pif.busy} !== 2'b01) $display("FAIL timeout_error_clear: got error,busy=%b want 01", {pif.error, pif.busy}); else passed++;
    wait_busy(1'b0, 500, ok);
    tick(2);
    total++;
    if (!ok || pif.locked !== 1'b1 || wr_data.size() == 0 || wr_data[0] != 4)
      $display("FAIL timeout_recover: got ok %b locked %b M %0d want 1 1 4", ok, pif.locked, wr_data.size() ? wr_data[0] : -1);
    else passed++;
  endtask

  task automatic test_strobe_while_busy;
    bit ok, ok2;
    int n200;
    wr_type.delete(); wr_data.delete();
    strobe(100);
    for (int i = 0; i < 50 && wr_type.size() < 1; i++) @(negedge clk);
    strobe(200);
    for (int i = 0; i < 50 && wr_type.size() < 2; i++) @(negedge clk);
    strobe(300);
    wait_busy(1'b0, 500, ok);
    wait_busy(1'b1, 10, ok2);
    total++;
    if (!ok || !ok2) $display("FAIL pending_serviced: got done %b restart %b want 1 1", ok, ok2); else passed++;
    wait_busy(1'b0, 500, ok);
    tick(2);
    n200 = 0;
    foreach (wr_type[i]) if (wr_type[i] == 1 && wr_data[i] == 200) n200++;
    total++;
    if (wr_type.size() != 6) $display("FAIL pending_write_count: got %0d want 6", wr_type.size()); else passed++;
    total++;
    if (wr_type.size() < 4 || wr_type[3] != 1 || wr_data[3] != 300 || wr_data[0] != 100)
      $display("FAIL pending_latest_wins: got M %0d then %0d want 100 then 300",
               wr_data.size() ? wr_data[0] : -1, wr_data.size() > 3 ? wr_data[3] : -1);
    else passed++;
    total++;
    if (n200 != 0) $display("FAIL pending_no_200: got %0d writes of 200 want 0", n200); else passed++;
  endtask

  task automatic test_async_reset;
    bit seen_ar;
    int n0, a0;
    seen_ar = 1'b0;
    strobe(120);
    for (int i = 0; i < 200 && !seen_ar; i++) begin
      @(negedge clk);
      seen_ar = pif.pll_areset;
    end
    tick(3);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (!seen_ar || {pif.pll_areset, pif.busy, pif.locked} !== 3'b000)
      $display("FAIL async_status: got seen %b areset,busy,locked=%b want 1 000", seen_ar, {pif.pll_areset, pif.busy, pif.locked});
    else passed++;
    total++;
    if ({pif.rc_counter_type, pif.rc_counter_param, pif.rc_data_in, pif.rc_write_param, pif.rc_reconfig} !== 18'd0)
      $display("FAIL async_rc: got %h want 0", {pif.rc_counter_type, pif.rc_counter_param, pif.rc_data_in, pif.rc_write_param, pif.rc_reconfig});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    n0 = wr_type.size(); a0 = n_ar;
    tick(30);
    total++;
    if (wr_type.size() != n0 || n_ar != a0 || pif.busy !== 1'b0 || pif.pll_areset !== 1'b0)
      $display("FAIL async_quiet: got writes %0d areset %0d busy %b want %0d %0d 0", wr_type.size(), n_ar, pif.busy, n0, a0);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_legal_retune;
    test_lock_loss;
    test_range_reject;
    test_lock_timeout;
    test_strobe_while_busy;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
